lut_config_loader: RTL
======================

# lut_config_loader

Drives the stream-style configuration chain of the LUT array (`config_en`/`config_in` on the first LUT, `config_out` daisy-chained). It accepts wide configuration words from the host over a valid/ready handshake and slices each word into `CONFIG_WIDTH` chunks. Each chunk is shifted into the chain with `config_en` asserted for exactly `CHAIN_WORDS` chunk cycles, after which it signals completion. It sits between the bitstream source (host/DMA) and the head of the LUT configuration chain, in the `config_clk` domain.

## Interface
- `CONFIG_WIDTH`, 8, chunk width; equals the LUT chain width.
- `IN_WIDTH`, 32, host word width; must be a multiple of `CONFIG_WIDTH`.
- `CHAIN_WORDS`, 16, total chunks in the chain (sum of `MEM_SIZE/CONFIG_WIDTH` over all LUTs); must be a multiple of `IN_WIDTH/CONFIG_WIDTH`.
- `config_clk`  in  1  the single clock.
- `config_rst_n`  in  1  reset; asynchronous, active-low.
- `start`  in  1  begin a load; ignored while `busy`.
- `host_data`  in  `IN_WIDTH`  configuration word.
- `host_valid`  in  1  `host_data` valid.
- `host_ready`  out  1  loader accepts word this cycle.
- `config_en`  out  1  chain shift enable, to first LUT `config_en`.
- `config_data`  out  `CONFIG_WIDTH`  chunk, to first LUT `config_in`.
- `busy`  out  1  load in progress.
- `done`  out  1  one-cycle pulse at end of load.
- `err`  out  1  checksum mismatch, sticky until next `start`.

## Operation
- States:
  - IDLE: `start` → FETCH; clears `err` and counters.
  - FETCH: wait for a handshake into the one-word holding register.
  - SHIFT: emit the chunks of the held word.
  - CHECK: only with the macro.
  - DONE: one cycle, back to IDLE.
- Chunk order: LSB chunk first. The first host word reaches the far end of the chain, so host words are sent far-end-first.
- `SUBS = IN_WIDTH/CONFIG_WIDTH`; word count `NW = CHAIN_WORDS/SUBS`.
- Counters:
  - `chunk_idx`, 0..SUBS-1.
  - `chunk_cnt`, 0..CHAIN_WORDS-1; width `$clog2(CHAIN_WORDS)`, no wrap.
- `host_ready = busy && (holding register empty || last chunk of held word emitted this cycle)`. This permits gapless streaming.
- `config_en` and `config_data` are registered.
  - `config_en` is high only in cycles where a valid chunk is presented.
  - If the holding register is empty (host stall), `config_en` is low, the chain holds, and `config_data` holds its last value.
- After the chunk that brings `chunk_cnt` to CHAIN_WORDS, no further `config_en` is issued.
- `host_ready` is low after `NW` words (`NW+1` with the macro).
- `start` while `busy` is ignored. `start` in the DONE cycle is ignored; it is accepted from the following IDLE cycle.
- Reset mid-load:
  - All outputs go to 0 immediately.
  - Chain contents are undefined and a full restart is required.
  - No partial resume.

## Timing
- Reset values: `host_ready`, `config_en`, `config_data`, `busy`, `done`, `err` all 0.
- `start` sampled at cycle 0 → `busy`=1 at cycle 1, `host_ready` may be 1 at cycle 1.
- Word handshake at cycle t → chunks at cycles t+1..t+SUBS with `config_en`=1.
- With `host_valid` held high, `config_en` is high for exactly CHAIN_WORDS consecutive cycles.
- Last chunk at cycle L → `done`=1 and `busy`=0 at L+1. With the macro, `done` instead follows the checksum handshake by 1 cycle.

## Configuration
- `LUT_CONFIG_CHECKSUM_EN` defined:
  - Accumulate the XOR of all `NW` data words.
  - Accept one extra host word (the checksum) in CHECK; it produces no `config_en`.
  - Mismatch → `err`=1 in the same cycle `done` pulses.
- Not defined: no extra word, no accumulator, `err` tied 0.

## Structure
- Shared package `lut_cfg_pkg`:
  - FSM state enum (IDLE, FETCH, SHIFT, CHECK, DONE).
  - `SUBS`/`NW` derivation functions.
  - Default `CONFIG_WIDTH`.
- One sub-module: `cfg_word_serializer`, containing the holding register, `chunk_idx` and the chunk mux, with `in_valid`/`in_ready`/`out_en`/`out_data`. The FSM and counters live in the top.

## Test plan
Configuration for all cases: `CONFIG_WIDTH`=8, `IN_WIDTH`=16, `CHAIN_WORDS`=4, with a behavioural 4-stage chain model.
- Gapless load: `start`, then words 0xBBAA and 0xDDCC with `host_valid` always high.
  - `config_en` high 4 consecutive cycles; `config_data` = AA, BB, CC, DD.
  - Chain far→near reads AA, BB, CC, DD; `done` pulses once.
- Host stall: 3 idle cycles between the two words → `config_en` low exactly 3 cycles, final chain contents identical, `done` 3 cycles later than gapless.
- Ignored start: `start` pulsed mid-load and in the DONE cycle → no extra words accepted, `config_en` count stays 4.
- Reset mid-load: `config_rst_n` asserted after 2 chunks.
  - All outputs 0 asynchronously.
  - After release and `start`, a full 4-chunk load completes correctly.
- Checksum (macro on):
  - Words 0xBBAA, 0xDDCC, checksum 0x6666 → `err`=0.
  - Checksum 0x0000 → `err`=1 with `done`, cleared on next `start`.
- Over-supply: `host_valid` held high after the last word → `host_ready` stays 0 after `NW` words and no 5th `config_en`.

Source files
------------

// File: rtl/lut_cfg_pkg.sv
// ============================================================================
// Module      : lut_cfg_pkg
// Description : Shared definitions for the LUT configuration loader. Holds the
//               loader FSM state encoding, the default chain chunk width and
//               helpers that derive chunks-per-word and words-per-load.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package lut_cfg_pkg;

    // Chunk width of the LUT configuration chain.
    localparam int DEFAULT_CONFIG_WIDTH = 8;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_SHIFT = 3'd2,
        ST_CHECK = 3'd3,
        ST_DONE  = 3'd4
    } cfg_state_e;

    // Chunks carried by one host word.
    function automatic int calc_subs(input int in_width, input int cfg_width);
        return in_width / cfg_width;
    endfunction

    // Host words needed to fill the whole chain.
    function automatic int calc_nw(input int chain_words, input int subs);
        return chain_words / subs;
    endfunction

    // Counter width that never collapses to zero bits.
    function automatic int safe_clog2(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/cfg_word_serializer.sv
// ============================================================================
// Module      : cfg_word_serializer
// Description : One-word holding register that slices a host word into
//               CONFIG_WIDTH chunks, LSB chunk first. The chunk register is
//               loaded straight from in_data on the accepting edge, so the
//               first chunk is presented the cycle after the handshake.
// Ports       : clk, rst_n      - clock, asynchronous active-low reset
//               accept_en      - upstream allows another word to be taken
//               in_valid/in_data/in_ready - word handshake
//               out_en/out_data - registered chunk stream
//               out_last       - the chunk presented now is the word's last
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cfg_word_serializer
    import lut_cfg_pkg::*;
#(
    parameter int CONFIG_WIDTH = DEFAULT_CONFIG_WIDTH,
    parameter int IN_WIDTH     = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    accept_en,
    input  logic                    in_valid,
    input  logic [IN_WIDTH-1:0]     in_data,
    output logic                    in_ready,
    output logic                    out_en,
    output logic [CONFIG_WIDTH-1:0] out_data,
    output logic                    out_last
);

    localparam int SUBS  = calc_subs(IN_WIDTH, CONFIG_WIDTH);
    localparam int IDX_W = safe_clog2(SUBS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SUBS - 1);

    logic [IN_WIDTH-1:0]     word_q, word_d;
    logic                    full_q, full_d;   // a chunk of word_q is on out_data
    logic [IDX_W-1:0]        chunk_idx_q, chunk_idx_d;
    logic [CONFIG_WIDTH-1:0] data_q, data_d;
    logic [IDX_W-1:0]        w_next_idx;
    logic                    w_last;
    logic                    w_take;

    assign w_last     = full_q && (chunk_idx_q == LAST_IDX);
    // Taking a new word while the last chunk is on the wire keeps the stream gapless.
    assign in_ready   = accept_en && (!full_q || w_last);
    assign w_take     = in_valid && in_ready;
    assign w_next_idx = chunk_idx_q + 1'b1;

    always_comb begin
        word_d      = word_q;
        full_d      = full_q;
        chunk_idx_d = chunk_idx_q;
        data_d      = data_q;
        if (w_take) begin
            word_d      = in_data;
            full_d      = 1'b1;
            chunk_idx_d = '0;
            data_d      = in_data[CONFIG_WIDTH-1:0];
        end else if (full_q && !w_last) begin
            chunk_idx_d = w_next_idx;
            data_d      = word_q[int'(w_next_idx) * CONFIG_WIDTH +: CONFIG_WIDTH];
        end else if (w_last) begin
            // Drained with nothing new: drop enable, keep the last chunk value.
            full_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word_q      <= '0;
            full_q      <= 1'b0;
            chunk_idx_q <= '0;
            data_q      <= '0;
        end else begin
            word_q      <= word_d;
            full_q      <= full_d;
            chunk_idx_q <= chunk_idx_d;
            data_q      <= data_d;
        end
    end

    assign out_en   = full_q;
    assign out_data = data_q;
    assign out_last = w_last;

endmodule

`default_nettype wire

// File: rtl/lut_config_loader.sv
// ============================================================================
// Module      : lut_config_loader
// Description : Loads the LUT configuration chain from a host word stream.
//               Each accepted word is serialised LSB chunk first onto
//               config_en/config_data; after CHAIN_WORDS chunks the load ends
//               with a one-cycle done pulse. Host words go far-end-first.
// Option      : LUT_CONFIG_CHECKSUM_EN - accept one extra word after the data
//               and compare it with the XOR of all data words; mismatch sets
//               err (sticky until the next start). Undefined: err is 0.
// Ports       : config_clk, config_rst_n (async active-low)
//               start, host_data/host_valid/host_ready (host side)
//               config_en, config_data (chain head), busy, done, err
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module lut_config_loader
    import lut_cfg_pkg::*;
#(
    parameter int CONFIG_WIDTH = DEFAULT_CONFIG_WIDTH,
    parameter int IN_WIDTH     = 32,
    parameter int CHAIN_WORDS  = 16
) (
    input  logic                    config_clk,
    input  logic                    config_rst_n,
    input  logic                    start,
    input  logic [IN_WIDTH-1:0]     host_data,
    input  logic                    host_valid,
    output logic                    host_ready,
    output logic                    config_en,
    output logic [CONFIG_WIDTH-1:0] config_data,
    output logic                    busy,
    output logic                    done,
    output logic                    err
);

    localparam int SUBS   = calc_subs(IN_WIDTH, CONFIG_WIDTH);
    localparam int NW     = calc_nw(CHAIN_WORDS, SUBS);
    localparam int CNT_W  = safe_clog2(CHAIN_WORDS);
    localparam int WCNT_W = safe_clog2(NW + 1);
    localparam logic [CNT_W-1:0]  LAST_CHUNK = CNT_W'(CHAIN_WORDS - 1);
    localparam logic [WCNT_W-1:0] NW_W       = WCNT_W'(NW);

    cfg_state_e          state_q, state_d;
    logic [CNT_W-1:0]    chunk_cnt_q, chunk_cnt_d;
    logic [WCNT_W-1:0]   word_cnt_q, word_cnt_d;

    logic                w_accept_en;
    logic                w_ser_ready;
    logic                w_ser_en;
    logic                w_ser_last;
    logic [CONFIG_WIDTH-1:0] w_ser_data;
    logic                w_data_hs;
    logic                w_final;

`ifdef LUT_CONFIG_CHECKSUM_EN
    logic                err_q, err_d;
    logic [IN_WIDTH-1:0] csum_q, csum_d;
`endif

    // Data words are only taken while loading and until NW have been accepted.
    assign w_accept_en = ((state_q == ST_FETCH) || (state_q == ST_SHIFT)) &&
                         (word_cnt_q < NW_W);
    assign w_data_hs   = host_valid && w_ser_ready;
    // The chunk on the wire now is the last one the chain needs.
    assign w_final     = w_ser_en && (chunk_cnt_q == LAST_CHUNK);

    cfg_word_serializer #(
        .CONFIG_WIDTH (CONFIG_WIDTH),
        .IN_WIDTH     (IN_WIDTH)
    ) u_serializer (
        .clk       (config_clk),
        .rst_n     (config_rst_n),
        .accept_en (w_accept_en),
        .in_valid  (host_valid),
        .in_data   (host_data),
        .in_ready  (w_ser_ready),
        .out_en    (w_ser_en),
        .out_data  (w_ser_data),
        .out_last  (w_ser_last)
    );

    always_comb begin
        state_d     = state_q;
        chunk_cnt_d = chunk_cnt_q;
        word_cnt_d  = word_cnt_q;
`ifdef LUT_CONFIG_CHECKSUM_EN
        err_d       = err_q;
        csum_d      = csum_q;
`endif
        if (w_data_hs) begin
            word_cnt_d = word_cnt_q + 1'b1;
`ifdef LUT_CONFIG_CHECKSUM_EN
            csum_d     = csum_q ^ host_data;
`endif
        end
        // Saturates at the last chunk; the FSM leaves SHIFT on that cycle.
        if (w_ser_en && !w_final) begin
            chunk_cnt_d = chunk_cnt_q + 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d     = ST_FETCH;
                    chunk_cnt_d = '0;
                    word_cnt_d  = '0;
`ifdef LUT_CONFIG_CHECKSUM_EN
                    err_d       = 1'b0;
                    csum_d      = '0;
`endif
                end
            end
            ST_FETCH: begin
                if (w_data_hs) begin
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (w_final) begin
`ifdef LUT_CONFIG_CHECKSUM_EN
                    state_d = ST_CHECK;
`else
                    state_d = ST_DONE;
`endif
                end else if (w_ser_last && !w_data_hs) begin
                    state_d = ST_FETCH;
                end
            end
            ST_CHECK: begin
`ifdef LUT_CONFIG_CHECKSUM_EN
                if (host_valid) begin
                    err_d   = (host_data != csum_q);
                    state_d = ST_DONE;
                end
`else
                state_d = ST_IDLE;
`endif
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge config_clk or negedge config_rst_n) begin
        if (!config_rst_n) begin
            state_q     <= ST_IDLE;
            chunk_cnt_q <= '0;
            word_cnt_q  <= '0;
`ifdef LUT_CONFIG_CHECKSUM_EN
            err_q       <= 1'b0;
            csum_q      <= '0;
`endif
        end else begin
            state_q     <= state_d;
            chunk_cnt_q <= chunk_cnt_d;
            word_cnt_q  <= word_cnt_d;
`ifdef LUT_CONFIG_CHECKSUM_EN
            err_q       <= err_d;
            csum_q      <= csum_d;
`endif
        end
    end

    assign busy        = (state_q == ST_FETCH) || (state_q == ST_SHIFT) ||
                         (state_q == ST_CHECK);
    assign done        = (state_q == ST_DONE);
    assign config_en   = w_ser_en;
    assign config_data = w_ser_data;

`ifdef LUT_CONFIG_CHECKSUM_EN
    // The checksum word bypasses the serializer so it never reaches the chain.
    assign host_ready  = w_ser_ready || (state_q == ST_CHECK);
    assign err         = err_q;
`else
    assign host_ready  = w_ser_ready;
    assign err         = 1'b0;
`endif

endmodule

`default_nettype wire
